// File: rtl/dense_to_coo.sv
// Dense-to-COO encoder: snapshots a ROWS x COLS matrix, counts nonzeros,
// then streams a header triple followed by one triple per nonzero element.
module dense_to_coo #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROWS*COLS*DW-1:0]  dense_in,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_hdr,
    output logic [DW-1:0]            out_row,
    output logic [DW-1:0]            out_col,
    output logic [DW-1:0]            out_val
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NW = $clog2(N + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [NW-1:0] r_nnz;
    logic [N*DW-1:0] r_snap;

    logic [DW-1:0] w_elem;
    logic          w_nz;
    logic          w_last;
    logic          w_hdr;
    logic          w_emit;

    assign w_elem = r_snap[r_idx*DW +: DW];
    assign w_nz   = |w_elem;
    assign w_last = (r_idx == IW'(N - 1));
    assign w_hdr  = (r_state == S_HDR);
    assign w_emit = (r_state == S_EMIT) && w_nz;

    // Outputs decode registered state only; out_ready never reaches them.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign out_valid = w_hdr || w_emit;
    assign out_hdr   = w_hdr;
    assign out_row   = w_hdr ? DW'(ROWS) : (w_emit ? DW'(r_row) : '0);
    assign out_col   = w_hdr ? DW'(COLS) : (w_emit ? DW'(r_col) : '0);
    assign out_val   = w_hdr ? DW'(r_nnz) : (w_emit ? w_elem : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_nnz   <= '0;
            r_snap  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap  <= dense_in;
                        r_idx   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_nnz   <= '0;
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    r_nnz <= r_nnz + NW'(w_nz);
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= S_HDR;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        r_idx   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // Zeros advance unconditionally; nonzeros wait for the handshake.
                    if (!w_nz || out_ready) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            if (r_col == CW'(COLS - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + RW'(1);
                            end else begin
                                r_col <= r_col + CW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dense_to_coo.md
# dense_to_coo

Dense-to-COO encoder for the sparse-matrix datapath. It snapshots a dense ROWS×COLS matrix and streams it out in COO form over a valid/ready interface. The stream is one header word-triple {ROWS, COLS, nnz} followed by one {row, col, val} triple per nonzero element, in row-major order. This is the same COO triple layout that `coo_column` consumes, so the block is the producer for that consumer and for matrix-result write-back.

## Interface
Parameters:
- ROWS, default 4: matrix rows.
- COLS, default 4: matrix columns.
- DW, default 32: width of every triple field and every matrix element.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: request to encode; sampled only in IDLE.
- dense_in  in  ROWS*COLS*DW: flattened matrix. Element (r,c) is at bits [(r*COLS+c)*DW +: DW].
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse after the last triple has been handled.
- out_valid  out  1: a triple is presented.
- out_ready  in  1: downstream accepts the triple.
- out_hdr  out  1: the presented triple is the header.
- out_row  out  DW: row index, or ROWS for the header.
- out_col  out  DW: column index, or COLS for the header.
- out_val  out  DW: element value, or nnz for the header.

## Operation
- N = ROWS*COLS. Index idx runs 0..N-1 in row-major order: r = idx / COLS, c = idx % COLS.
- FSM states: IDLE, COUNT, HDR, EMIT, DONE.
- IDLE:
  - start=1 → capture dense_in into an internal snapshot, clear idx and nnz, go to COUNT.
  - Later changes to dense_in have no effect on the transfer in progress.
- COUNT:
  - One snapshot element per cycle; nnz += (elem != 0).
  - After idx = N-1 is processed, go to HDR.
  - nnz is $clog2(N+1) bits wide, zero-extended to DW on out_val.
- HDR:
  - Drive out_valid=1, out_hdr=1, out_row=ROWS, out_col=COLS, out_val=nnz.
  - On out_valid&&out_ready, set idx=0 and go to EMIT.
- EMIT:
  - Element idx zero → skip it in one cycle with out_valid=0, then idx++.
  - Element idx nonzero → drive out_valid=1, out_hdr=0, row/col/val of that element. Hold until the handshake, then idx++.
  - After idx = N-1 is handled (emitted or skipped), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- All outputs are driven from registered state only; there is no combinational path from out_ready to any output.
- While out_valid=1 && out_ready=0, out_hdr, out_row, out_col and out_val stay stable, and out_valid stays high until the handshake.
- start while busy=1 is ignored; it is neither queued nor restarted.
- Values are compared against zero over all DW bits; sign is irrelevant.
- Reset (asynchronous, any state):
  - State goes to IDLE; idx, nnz and the snapshot are cleared.
  - out_valid, out_hdr, busy and done go to 0 immediately, without waiting for a clock edge.
  - out_row, out_col and out_val reset to 0.
  - A triple in flight is abandoned; no partial completion and no done pulse.

## Timing
- Take the start-sampling edge as E0.
- COUNT occupies the cycles after E0..E(N-1); HDR is entered at edge E(N).
- With out_ready tied high:
  - The header handshake occurs at E(N+1).
  - EMIT takes exactly N cycles.
  - done is high in the cycle after E(2N+1), and busy falls at E(2N+2).
- Each cycle out_ready is held low during a presented triple adds exactly one cycle of latency.
- The earliest next start is sampled at the first edge after IDLE is re-entered.
- Throughput is one COO triple per cycle for consecutive nonzeros; zeros cost one idle cycle each.

## Test plan
- Matrix rows [4,0,0,2] [0,0,1,0] [0,2,0,0] [9,0,2,0], out_ready=1 → header {4,4,6}, then {0,0,4} {0,3,2} {1,2,1} {2,1,2} {3,0,9} {3,2,2}; done in the cycle after E33.
- All-zero matrix → header {4,4,0} only, no further out_valid; done in the cycle after E33.
- All-ones matrix with out_ready toggling 1,0,1,0 → header {4,4,16} then 16 triples (r,c,1) in row-major order. Outputs are stable through every stall and no triple is duplicated or dropped.
- Change dense_in and pulse start during EMIT → stream still matches the captured snapshot; no restart.
- Assert rst while the 3rd triple is held with out_ready=0 → out_valid, busy and done drop immediately. A new start after reset release produces a full, correct stream from the header.
- Element value 0x8000_0000 at (2,3), all others zero → header {4,4,1}, then {2,3,0x8000_0000}.
